// File: rtl/yonga_lz4_frame_parser_if.sv
// Byte-stream handshake and fifo1 write bus of the LZ4 frame parser.
//   i_in_valid / i_in_data / o_in_ready : raw frame byte input
//   i_fifo1_full                        : decoder input FIFO full
//   o_fifo1_write / o_fifo1_data        : byte write into fifo1
// master: drives the frame stream and the FIFO status (source side).
// slave : the parser itself.
interface yonga_lz4_frame_parser_if;
  logic       i_in_valid;
  logic [7:0] i_in_data;
  logic       o_in_ready;
  logic       i_fifo1_full;
  logic       o_fifo1_write;
  logic [7:0] o_fifo1_data;

  modport master (
    output i_in_valid, i_in_data, i_fifo1_full,
    input  o_in_ready, o_fifo1_write, o_fifo1_data
  );

  modport slave (
    input  i_in_valid, i_in_data, i_fifo1_full,
    output o_in_ready, o_fifo1_write, o_fifo1_data
  );
endinterface

// File: rtl/yonga_lz4_frame_parser.sv
// LZ4 frame parser: validates and strips the frame header, forwards each
// block's 4-byte size word and payload into fifo1, appends four zero
// end-of-block bytes per block, and drops block/content checksums and the
// EndMark.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_enable       : allows a new frame to start
//   i_clear        : leaves ERROR back to MAGIC
//   bus (slave)    : byte input handshake and fifo1 write port
//   o_idle         : waiting for the first magic byte
//   o_frame_done   : one-cycle pulse after a frame is consumed
//   o_error        : sticky error flag
//   o_error_code   : 1 bad magic, 2 bad FLG version, 3 bad block size
module yonga_lz4_frame_parser #(
  parameter int unsigned MAX_BLOCK_SIZE = 4194304
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_enable,
  input  logic                           i_clear,
  yonga_lz4_frame_parser_if.slave        bus,
  output logic                           o_idle,
  output logic                           o_frame_done,
  output logic                           o_error,
  output logic [1:0]                     o_error_code
);

  localparam logic [3:0] S_MAGIC     = 4'd0;
  localparam logic [3:0] S_FLG       = 4'd1;
  localparam logic [3:0] S_BD        = 4'd2;
  localparam logic [3:0] S_HDR_SKIP  = 4'd3;
  localparam logic [3:0] S_BSIZE     = 4'd4;
  localparam logic [3:0] S_BSIZE_FWD = 4'd5;
  localparam logic [3:0] S_DATA      = 4'd6;
  localparam logic [3:0] S_EOB       = 4'd7;
  localparam logic [3:0] S_BCHK_SKIP = 4'd8;
  localparam logic [3:0] S_CCHK_SKIP = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;
  localparam logic [3:0] S_ERROR     = 4'd11;

  localparam logic [30:0] MAX_W = 31'(MAX_BLOCK_SIZE);

  logic [3:0]  r_state;
  logic [1:0]  r_idx;
  logic [30:0] r_cnt;
  logic [3:0]  r_skip;
  logic [31:0] r_size;
  logic        r_flg_cs;
  logic        r_flg_dict;
  logic        r_flg_bchk;
  logic        r_flg_cchk;
  logic [1:0]  r_err_code;

  logic        w_ready;
  logic        w_accept;
  logic        w_wr;
  logic [7:0]  w_wdata;
  logic [7:0]  w_magic;
  logic [7:0]  w_size_byte;
  logic [31:0] w_word;

  // Size word as it stands once the current (4th) byte is shifted in.
  assign w_word   = {bus.i_in_data, r_size[31:8]};
  assign w_accept = bus.i_in_valid && w_ready;

  always_comb begin
    w_magic = 8'h04;
    case (r_idx)
      2'd0: w_magic = 8'h04;
      2'd1: w_magic = 8'h22;
      2'd2: w_magic = 8'h4D;
      default: w_magic = 8'h18;
    endcase
  end

  always_comb begin
    w_size_byte = r_size[7:0];
    case (r_idx)
      2'd0: w_size_byte = r_size[7:0];
      2'd1: w_size_byte = r_size[15:8];
      2'd2: w_size_byte = r_size[23:16];
      default: w_size_byte = r_size[31:24];
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_MAGIC:     w_ready = i_enable || (r_idx != 2'd0);
      S_FLG, S_BD, S_HDR_SKIP, S_BSIZE,
      S_BCHK_SKIP, S_CCHK_SKIP: w_ready = 1'b1;
      S_DATA:      w_ready = !bus.i_fifo1_full;
      default:     w_ready = 1'b0;
    endcase
    if (rst) w_ready = 1'b0;
  end

  always_comb begin
    w_wr    = 1'b0;
    w_wdata = '0;
    case (r_state)
      S_BSIZE_FWD: begin
        w_wr    = !bus.i_fifo1_full;
        w_wdata = w_size_byte;
      end
      S_DATA: begin
        w_wr    = w_accept;
        w_wdata = bus.i_in_data;
      end
      S_EOB: begin
        w_wr    = !bus.i_fifo1_full;
        w_wdata = '0;
      end
      default: ;
    endcase
    if (rst) w_wr = 1'b0;
  end

  assign bus.o_in_ready    = w_ready;
  assign bus.o_fifo1_write = w_wr;
  assign bus.o_fifo1_data  = w_wdata;

  assign o_idle       = (r_state == S_MAGIC) && (r_idx == 2'd0);
  assign o_frame_done = (r_state == S_DONE);
  assign o_error      = (r_state == S_ERROR);
  assign o_error_code = r_err_code;

  // r_idx is a 2-bit wrapping index; every 4-byte phase ends with it back at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_MAGIC;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_skip     <= '0;
      r_size     <= '0;
      r_flg_cs   <= 1'b0;
      r_flg_dict <= 1'b0;
      r_flg_bchk <= 1'b0;
      r_flg_cchk <= 1'b0;
      r_err_code <= '0;
    end else begin
      case (r_state)
        S_MAGIC: if (w_accept) begin
          if (bus.i_in_data != w_magic) begin
            r_state    <= S_ERROR;
            r_err_code <= 2'd1;
          end else begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_FLG;
          end
        end
        S_FLG: if (w_accept) begin
          if (bus.i_in_data[7:6] != 2'b01) begin
            r_state    <= S_ERROR;
            r_err_code <= 2'd2;
          end else begin
            r_flg_cs   <= bus.i_in_data[3];
            r_flg_dict <= bus.i_in_data[0];
            r_flg_bchk <= bus.i_in_data[4];
            r_flg_cchk <= bus.i_in_data[2];
            r_state    <= S_BD;
          end
        end
        S_BD: if (w_accept) begin
          // Optional content size (8) and dict id (4), plus the HC byte.
          r_skip  <= {r_flg_cs, 3'b000} + {1'b0, r_flg_dict, 2'b00} + 4'd1;
          r_state <= S_HDR_SKIP;
        end
        S_HDR_SKIP: if (w_accept) begin
          r_skip <= r_skip - 4'd1;
          if (r_skip == 4'd1) r_state <= S_BSIZE;
        end
        S_BSIZE: if (w_accept) begin
          r_size <= w_word;
          r_idx  <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            if (w_word == 32'd0) begin
              if (r_flg_cchk) begin
                r_skip  <= 4'd4;
                r_state <= S_CCHK_SKIP;
              end else begin
                r_state <= S_DONE;
              end
            end else if (w_word[30:0] > MAX_W || w_word[30:0] == 31'd0) begin
              r_state    <= S_ERROR;
              r_err_code <= 2'd3;
            end else begin
              r_state <= S_BSIZE_FWD;
            end
          end
        end
        S_BSIZE_FWD: if (!bus.i_fifo1_full) begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_cnt   <= r_size[30:0];
            r_state <= S_DATA;
          end
        end
        S_DATA: if (w_accept) begin
          r_cnt <= r_cnt - 31'd1;
          if (r_cnt == 31'd1) r_state <= S_EOB;
        end
        S_EOB: if (!bus.i_fifo1_full) begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            if (r_flg_bchk) begin
              r_skip  <= 4'd4;
              r_state <= S_BCHK_SKIP;
            end else begin
              r_state <= S_BSIZE;
            end
          end
        end
        S_BCHK_SKIP: if (w_accept) begin
          r_skip <= r_skip - 4'd1;
          if (r_skip == 4'd1) r_state <= S_BSIZE;
        end
        S_CCHK_SKIP: if (w_accept) begin
          r_skip <= r_skip - 4'd1;
          if (r_skip == 4'd1) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_MAGIC;
        S_ERROR: if (i_clear) begin
          r_state    <= S_MAGIC;
          r_idx      <= '0;
          r_err_code <= '0;
        end
        default: r_state <= S_MAGIC;
      endcase
    end
  end

endmodule

// File: tb/tb_yonga_lz4_frame_parser.sv
// Self-checking bench for yonga_lz4_frame_parser. Frames are built from
// their structural description; the builder also produces the exact byte
// sequence fifo1 must receive, which a negedge monitor compares write by
// write.
module tb_yonga_lz4_frame_parser;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_enable = 1'b1;
  logic       i_clear = 1'b0;
  logic       o_idle;
  logic       o_frame_done;
  logic       o_error;
  logic [1:0] o_error_code;

  yonga_lz4_frame_parser_if bus();

  yonga_lz4_frame_parser #(.MAX_BLOCK_SIZE(4194304)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_clear      (i_clear),
    .bus          (bus.slave),
    .o_idle       (o_idle),
    .o_frame_done (o_frame_done),
    .o_error      (o_error),
    .o_error_code (o_error_code)
  );

  always #5 clk = ~clk;

  logic [7:0] frm[$];
  logic [7:0] expq[$];
  int pos = 0;
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int full_mode = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Per-cycle monitor of the fifo1 write port.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", {31'd0, bus.o_in_ready}, 32'd0);
      check("rst_fifo1_write", {31'd0, bus.o_fifo1_write}, 32'd0);
    end else begin
      if (bus.i_fifo1_full) check("write_while_full", {31'd0, bus.o_fifo1_write}, 32'd0);
      if (bus.o_fifo1_write) begin
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL fifo1_extra_write: got %02h, expected no write", bus.o_fifo1_data);
        end else begin
          check("fifo1_data", {24'd0, bus.o_fifo1_data}, {24'd0, expq.pop_front()});
        end
      end
      if (o_frame_done) done_cnt++;
    end
  end

  task automatic put(input logic [7:0] b);
    frm.push_back(b);
  endtask

  task automatic put_rnd();
    frm.push_back(8'($urandom));
  endtask

  task automatic put_both(input logic [7:0] b);
    frm.push_back(b);
    expq.push_back(b);
  endtask

  // Appends one frame to frm and the bytes fifo1 must see to expq.
  task automatic gen_frame(input logic [7:0] flg, input int nblk, input int minlen,
                           input int maxlen, input bit allow_unc);
    logic [31:0] w;
    int unsigned n;
    put(8'h04); put(8'h22); put(8'h4D); put(8'h18);
    put(flg); put(8'h40);
    if (flg[3]) repeat (8) put_rnd();
    if (flg[0]) repeat (4) put_rnd();
    put_rnd();
    for (int b = 0; b < nblk; b++) begin
      n = $urandom_range(maxlen, minlen);
      w = {allow_unc && ($urandom_range(0, 1) == 1), 31'(n)};
      for (int k = 0; k < 4; k++) put_both(w[8*k +: 8]);
      repeat (n) put_both(8'($urandom));
      repeat (4) expq.push_back(8'h00);
      if (flg[4]) repeat (4) put_rnd();
    end
    repeat (4) put(8'h00);
    if (flg[2]) repeat (4) put_rnd();
  endtask

  task automatic set_full();
    case (full_mode)
      0:       bus.i_fifo1_full = 1'b0;
      1:       bus.i_fifo1_full = ($urandom_range(0, 3) == 0);
      default: bus.i_fifo1_full = 1'b1;
    endcase
  endtask

  // Presents frm[pos..stop_at-1] with random valid bubbles; entered and left
  // 1 time unit after a rising edge.
  task automatic drive_to(input int stop_at);
    int cyc;
    bit acc;
    bit stuck;
    cyc = 0;
    stuck = 1'b0;
    while (pos < stop_at && pos < frm.size() && !stuck) begin
      bus.i_in_valid = ($urandom_range(0, 4) != 0);
      bus.i_in_data  = frm[pos];
      set_full();
      @(negedge clk);
      acc = bus.i_in_valid && bus.o_in_ready;
      @(posedge clk); #1;
      if (acc) pos++;
      cyc++;
      if (cyc > 3000) begin
        n_checks++;
        $display("FAIL drive_timeout: got byte %0d accepted, required %0d", pos, stop_at);
        stuck = 1'b1;
      end
    end
    bus.i_in_valid   = 1'b0;
    bus.i_fifo1_full = 1'b0;
  endtask

  task automatic drain(input int target);
    int cyc;
    cyc = 0;
    bus.i_in_valid = 1'b0;
    while (done_cnt < target && cyc < 300) begin
      set_full();
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_fifo1_full = 1'b0;
    check("frame_done_count", done_cnt, target);
    @(posedge clk); #1;
    check("expq_drained", expq.size(), 32'd0);
    check("idle_after_frame", {31'd0, o_idle}, 32'd1);
  endtask

  task automatic hold_full(input int n);
    repeat (n) begin
      bus.i_fifo1_full = 1'b1;
      bus.i_in_valid   = 1'b1;
      bus.i_in_data    = frm[pos];
      @(negedge clk);
      check("bp_in_ready", {31'd0, bus.o_in_ready}, 32'd0);
      check("bp_fifo1_write", {31'd0, bus.o_fifo1_write}, 32'd0);
      @(posedge clk); #1;
    end
    bus.i_fifo1_full = 1'b0;
    bus.i_in_valid   = 1'b0;
  endtask

  task automatic new_frame();
    frm.delete();
    pos = 0;
  endtask

  task automatic expect_error(input logic [1:0] code);
    @(negedge clk);
    check("err_flag", {31'd0, o_error}, 32'd1);
    check("err_code", {30'd0, o_error_code}, {30'd0, code});
    check("err_in_ready", {31'd0, bus.o_in_ready}, 32'd0);
    @(posedge clk); #1;
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    @(negedge clk);
    check("clear_error", {31'd0, o_error}, 32'd0);
    check("clear_code", {30'd0, o_error_code}, 32'd0);
    check("clear_idle", {31'd0, o_idle}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic put_hdr();
    put(8'h04); put(8'h22); put(8'h4D); put(8'h18); put(8'h40); put(8'h40); put(8'hC7);
  endtask

  initial begin
    int tgt;
    logic [7:0] lit[];
    bus.i_in_valid   = 1'b0;
    bus.i_in_data    = 8'h00;
    bus.i_fifo1_full = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_idle", {31'd0, o_idle}, 32'd1);
    check("reset_error", {31'd0, o_error}, 32'd0);
    check("reset_code", {30'd0, o_error_code}, 32'd0);
    check("reset_done", {31'd0, o_frame_done}, 32'd0);
    check("reset_write", {31'd0, bus.o_fifo1_write}, 32'd0);
    check("reset_ready", {31'd0, bus.o_in_ready}, 32'd1);
    @(posedge clk); #1;

    // Disabled parser must not start a frame.
    i_enable = 1'b0;
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = 8'h04;
    repeat (3) begin
      @(negedge clk);
      check("enable_low_ready", {31'd0, bus.o_in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.i_in_valid = 1'b0;
    i_enable = 1'b1;
    check("enable_low_idle", {31'd0, o_idle}, 32'd1);

    // Minimal frame, literal expectation.
    new_frame();
    put_hdr();
    lit = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    foreach (lit[i]) put(lit[i]);
    repeat (4) put(8'h00);
    expq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    tgt = done_cnt + 1;
    drive_to(frm.size());
    drain(tgt);

    // FLG=5C: content size, block and content checksums dropped.
    new_frame();
    gen_frame(8'h5C, 2, 2, 2, 1'b0);
    check("model_5c_fifo_len", expq.size(), 32'd20);
    check("model_5c_frame_len", frm.size(), 32'd43);
    tgt = done_cnt + 1;
    drive_to(frm.size());
    drain(tgt);

    // Backpressure held mid-DATA and mid-EOB_INSERT.
    new_frame();
    put_hdr();
    for (int k = 0; k < 4; k++) put_both((k == 0) ? 8'h08 : 8'h00);
    repeat (8) put_both(8'($urandom));
    repeat (4) expq.push_back(8'h00);
    repeat (4) put(8'h00);
    tgt = done_cnt + 1;
    drive_to(14);
    hold_full(5);
    drive_to(19);
    hold_full(5);
    drive_to(frm.size());
    drain(tgt);

    // Bad magic, then bad FLG version.
    new_frame();
    put(8'h04); put(8'h22); put(8'h4E);
    drive_to(frm.size());
    expect_error(2'd1);
    new_frame();
    put(8'h04); put(8'h22); put(8'h4D); put(8'h18); put(8'h80);
    drive_to(frm.size());
    expect_error(2'd2);

    // A valid frame right after clearing.
    new_frame();
    gen_frame(8'h40, 1, 1, 6, 1'b0);
    tgt = done_cnt + 1;
    drive_to(frm.size());
    drain(tgt);

    // Size one above the limit, and a zero size with the uncompressed bit.
    new_frame();
    put_hdr();
    put(8'h01); put(8'h00); put(8'h40); put(8'h00);
    drive_to(frm.size());
    expect_error(2'd3);
    new_frame();
    put_hdr();
    put(8'h00); put(8'h00); put(8'h00); put(8'h80);
    drive_to(frm.size());
    expect_error(2'd3);

    // Uncompressed block of 2 bytes, forwarded verbatim.
    new_frame();
    put_hdr();
    lit = '{8'h02, 8'h00, 8'h00, 8'h80, 8'hAA, 8'hBB};
    foreach (lit[i]) put(lit[i]);
    repeat (4) put(8'h00);
    expq = '{8'h02, 8'h00, 8'h00, 8'h80, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00};
    tgt = done_cnt + 1;
    drive_to(frm.size());
    drain(tgt);

    // Size exactly at the limit is accepted; reset lands mid-DATA.
    new_frame();
    put_hdr();
    put_both(8'h00); put_both(8'h00); put_both(8'h40); put_both(8'h00);
    repeat (5) put_both(8'($urandom));
    drive_to(frm.size());
    @(negedge clk);
    check("max_size_no_error", {31'd0, o_error}, 32'd0);
    check("max_size_fwd_all", expq.size(), 32'd0);
    @(posedge clk); #1;
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = 8'h5A;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, bus.o_in_ready}, 32'd0);
    check("rst_mid_write", {31'd0, bus.o_fifo1_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", {31'd0, o_idle}, 32'd1);
    check("rst_mid_error", {31'd0, o_error}, 32'd0);
    @(posedge clk); #1;

    // Random back-to-back frame pairs with random FIFO backpressure.
    for (int it = 0; it < 15; it++) begin
      full_mode = $urandom_range(0, 1);
      new_frame();
      repeat (2) gen_frame(8'h40 | (8'($urandom) & 8'h3D), $urandom_range(1, 3), 1, 12, 1'b1);
      tgt = done_cnt + 2;
      drive_to(frm.size());
      drain(tgt);
    end
    full_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/yonga_lz4_frame_parser.md
Name: yonga_lz4_frame_parser

Overview:
- Upstream neighbour of the LZ4 decoder controller. It takes a raw LZ4 frame as a byte stream and validates and strips the frame header.
- For each data block it forwards the 4-byte block size and the block payload into the decoder's input FIFO (fifo1).
- After each forwarded block it inserts the 4 zero end-of-block bytes the decoder consumes.
- It discards block checksums, the content checksum and the EndMark, so the decoder sees only size/data/zero-marker sequences.

Parameters:
- MAX_BLOCK_SIZE, 4194304: largest legal block payload in bytes; a larger size word is an error.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- i_enable  input  1  parser may leave IDLE/start a frame only when high.
- i_clear  input  1  one-cycle pulse; leaves ERROR and returns to MAGIC.
- i_in_valid  input  1  input byte valid.
- i_in_data  input  8  frame byte.
- o_in_ready  output  1  parser accepts i_in_data this cycle.
- i_fifo1_full  input  1  decoder input FIFO full.
- o_fifo1_write  output  1  write strobe into fifo1.
- o_fifo1_data  output  8  byte written into fifo1.
- o_idle  output  1  waiting for the first magic byte.
- o_frame_done  output  1  one-cycle pulse when a frame has been fully consumed.
- o_error  output  1  sticky error flag.
- o_error_code  output  2  error cause: 1 = bad magic, 2 = bad FLG version, 3 = block size > MAX_BLOCK_SIZE.

Behaviour:
- Accept: a byte is accepted when i_in_valid && o_in_ready.
- o_in_ready is combinational:
  - forwarding states: !i_fifo1_full;
  - skip/header states: 1;
  - EOB_INSERT, ERROR and DONE: 0;
  - forced to 0 while rst is high, or when i_enable=0 in MAGIC with byte index 0.
- fifo1 outputs are combinational:
  - forwarding states: o_fifo1_write = accept and o_fifo1_data = i_in_data;
  - EOB_INSERT: o_fifo1_write = !i_fifo1_full and o_fifo1_data = 8'h00.
  - There is no write while full and no latency, so each byte goes in the same cycle it is accepted.
- Reset: state=MAGIC, all counters 0, o_idle=1, o_frame_done=0, o_error=0, o_error_code=0, o_in_ready=0, o_fifo1_write=0. Reset mid-frame discards the partial frame; nothing is flushed to fifo1.
- Registered flags: FLG bits latched (content-size, dict-id, block-checksum, content-checksum); 2-bit byte index; 31-bit remaining-byte counter; 4-bit skip counter.
- State transitions (one byte consumed per accept):
  - MAGIC: expect 04,22,4D,18 in order. Any mismatch -> ERROR (code 1). After the 4th byte -> FLG.
  - FLG: bits[7:6] must equal 01, else ERROR (code 2). Latch bit3 (content size), bit0 (dict id), bit4 (block checksum), bit2 (content checksum). -> BD.
  - BD: ignored. -> HDR_SKIP with skip count = 8·bit3 + 4·bit0 + 1 (the +1 covers HC, which is not verified).
  - HDR_SKIP: count down per accept; at 0 -> BSIZE.
  - BSIZE: buffer the 4 little-endian bytes without forwarding.
    - After the 4th byte, if the whole word is 0 (EndMark) -> CCHK_SKIP (4 bytes if content-checksum flag, else go directly to DONE).
    - If size[30:0] > MAX_BLOCK_SIZE -> ERROR (code 3).
    - If size[30:0] == 0 with bit31=1 -> ERROR (code 3).
    - Otherwise -> BSIZE_FWD.
  - BSIZE_FWD: write the 4 buffered bytes to fifo1, one per cycle when !i_fifo1_full, consuming no input. Bit31 (uncompressed flag) is forwarded unchanged. Load counter = size[30:0]. -> DATA.
  - DATA: forward each byte and decrement; when the counter goes 1->0 -> EOB_INSERT.
  - EOB_INSERT: write four 00 bytes, one per non-full cycle. Then -> BCHK_SKIP (4 bytes) if block-checksum flag, else BSIZE.
  - DONE: o_frame_done=1 for one cycle. -> MAGIC.
  - ERROR: o_error=1; o_in_ready=0; input stalls. i_clear -> MAGIC with o_error and o_error_code cleared.
- Back-to-back frames are supported; o_idle=1 only in MAGIC with byte index 0.
- If i_clear and an error condition occur in the same cycle, the error wins.

Test Plan:
- Minimal frame: 04 22 4D 18, FLG=40, BD=40, HC, size 03 00 00 00, payload 11 22 33, EndMark 00000000 -> fifo1 receives exactly 03 00 00 00 11 22 33 00 00 00 00; o_frame_done pulses once; o_idle returns to 1.
- FLG=5C (content size, block checksum, content checksum), two 2-byte blocks -> 8-byte content size, HC, both block checksums and the content checksum are dropped; fifo1 gets 2 × (4 size + 2 data + 4 zeros) = 20 bytes.
- Backpressure: hold i_fifo1_full=1 for 5 cycles mid-DATA and mid-EOB_INSERT -> o_in_ready=0 and o_fifo1_write=0 throughout; no byte lost or duplicated; final byte order intact.
- Bad magic: 04 22 4E -> o_error=1, o_error_code=1, o_in_ready=0; i_clear pulse -> o_error=0, o_idle=1; a following valid frame parses correctly.
- Size word 01 00 40 00 (4194305) -> ERROR code 3, nothing forwarded. Size word with bit31=1 (uncompressed) and size 2 -> size bytes forwarded verbatim, then 2 data bytes, then 4 zeros.
- Assert rst in the middle of DATA -> next cycle o_in_ready=0, o_fifo1_write=0; after release the parser is in MAGIC and o_idle=1.
